// File: rtl/tdes_pass_sequencer.sv
// Triple-DES pass sequencer: drives a single-DES engine through three passes
// (E-D-E encrypt, D-E-D with reversed keys decrypt) and hands the result back.
module tdes_pass_sequencer #(
    parameter int TIMEOUT = 64
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        enable,
    input  logic        encryptionType,
    input  logic [63:0] data,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    input  logic        outputRead,
    output logic        des_start,
    output logic        des_mode,
    output logic [63:0] des_key,
    output logic [63:0] des_din,
    input  logic        des_done,
    input  logic [63:0] des_dout,
    output logic        outputEnable,
    output logic [63:0] outputData,
    output logic        outputError,
    output logic        busy,
    output logic        dropped
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic          enc_q, enc_d;
    logic [63:0]   data_q, data_d;
    logic [63:0]   k1_q, k1_d, k2_q, k2_d, k3_q, k3_d;
    logic [63:0]   work_q, work_d;
    logic [1:0]    pass_q, pass_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          des_start_q, des_start_d;
    logic          des_mode_q, des_mode_d;
    logic [63:0]   des_key_q, des_key_d;
    logic [63:0]   des_din_q, des_din_d;
    logic          oe_q, oe_d;
    logic [63:0]   odata_q, odata_d;
    logic          oerr_q, oerr_d;
    logic          busy_q, busy_d;
    logic          dropped_q, dropped_d;

    // Encrypt runs key1/key2/key3 as E,D,E; decrypt mirrors it as key3/key2/key1 D,E,D.
    function automatic logic [64:0] pass_cfg(input logic enc, input logic [1:0] p,
                                             input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] c);
        logic        m;
        logic [63:0] k;
        m = enc ? (p != 2'd1) : (p == 2'd1);
        if (p == 2'd1)      k = b;
        else if (p == 2'd0) k = enc ? a : c;
        else                k = enc ? c : a;
        return {m, k};
    endfunction

    always_comb begin
        state_d     = state_q;
        enc_d       = enc_q;
        data_d      = data_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        k3_d        = k3_q;
        work_d      = work_q;
        pass_d      = pass_q;
        timer_d     = timer_q;
        des_start_d = 1'b0;
        des_mode_d  = des_mode_q;
        des_key_d   = des_key_q;
        des_din_d   = des_din_q;
        oe_d        = oe_q;
        odata_d     = odata_q;
        oerr_d      = oerr_q;
        dropped_d   = dropped_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (enable) begin
                    state_d = ISSUE;
                    enc_d   = encryptionType;
                    data_d  = data;
                    k1_d    = key1;
                    k2_d    = key2;
                    k3_d    = key3;
                    pass_d  = 2'd0;
                    oe_d    = 1'b0;
                    oerr_d  = 1'b0;
                    odata_d = '0;
                end else if (state_q == DONE && outputRead) begin
                    state_d = IDLE;
                    oe_d    = 1'b0;
                    odata_d = '0;
                end
            end
            ISSUE: begin
                if (enable) dropped_d = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (enable) dropped_d = 1'b1;
                timer_d = timer_q + 1'b1;
                // A done in the timeout cycle still counts as success.
                if (des_done) begin
                    work_d = des_dout;
                    if (pass_q == 2'd2) begin
                        odata_d = des_dout;
                        oe_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        pass_d  = pass_q + 2'd1;
                        state_d = ISSUE;
                    end
                end else if (timer_q == TLAST) begin
                    oerr_d  = 1'b1;
                    odata_d = '0;
                    state_d = ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ISSUE) || (state_d == WAIT);
        if (state_d == ISSUE) begin
            des_start_d             = 1'b1;
            {des_mode_d, des_key_d} = pass_cfg(enc_d, pass_d, k1_d, k2_d, k3_d);
            des_din_d               = (pass_d == 2'd0) ? data_d : work_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q     <= IDLE;
            enc_q       <= 1'b0;
            data_q      <= '0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            work_q      <= '0;
            pass_q      <= '0;
            timer_q     <= '0;
            des_start_q <= 1'b0;
            des_mode_q  <= 1'b0;
            des_key_q   <= '0;
            des_din_q   <= '0;
            oe_q        <= 1'b0;
            odata_q     <= '0;
            oerr_q      <= 1'b0;
            busy_q      <= 1'b0;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            enc_q       <= enc_d;
            data_q      <= data_d;
            k1_q        <= k1_d;
            k2_q        <= k2_d;
            k3_q        <= k3_d;
            work_q      <= work_d;
            pass_q      <= pass_d;
            timer_q     <= timer_d;
            des_start_q <= des_start_d;
            des_mode_q  <= des_mode_d;
            des_key_q   <= des_key_d;
            des_din_q   <= des_din_d;
            oe_q        <= oe_d;
            odata_q     <= odata_d;
            oerr_q      <= oerr_d;
            busy_q      <= busy_d;
            dropped_q   <= dropped_d;
        end
    end

    assign des_start    = des_start_q;
    assign des_mode     = des_mode_q;
    assign des_key      = des_key_q;
    assign des_din      = des_din_q;
    assign outputEnable = oe_q;
    assign outputData   = odata_q;
    assign outputError  = oerr_q;
    assign busy         = busy_q;
    assign dropped      = dropped_q;

endmodule

// File: doc/tdes_pass_sequencer.md
Name: tdes_pass_sequencer

Overview:
- Sits directly downstream of the AHB-Lite slave controller and upstream of a single-DES engine.
- Consumes the controller's `enable` pulse, `encryptionType`, `data` and `key1`/`key2`/`key3`.
- Runs three sequential passes through the single-DES engine over a start/done handshake: E-D-E for encrypt, D-E-D with reversed keys for decrypt.
- Returns the result to the controller on `outputData`, qualified by `outputEnable`.

Parameters:
- TIMEOUT, 64, max cycles spent waiting for `des_done` in one pass before aborting (valid range 2..65535).

Ports:
- HCLK  in  1  clock, rising edge.
- HRESET  in  1  reset, asynchronous, active-low.
- enable  in  1  one-cycle request pulse from the slave controller.
- encryptionType  in  1  1 = encrypt, 0 = decrypt.
- data  in  64  input block.
- key1  in  64  key 1.
- key2  in  64  key 2.
- key3  in  64  key 3.
- outputRead  in  1  pulse: controller has consumed `outputData`.
- des_start  out  1  one-cycle start to the DES engine.
- des_mode  out  1  1 = DES encrypt, 0 = DES decrypt.
- des_key  out  64  key for the current pass.
- des_din  out  64  input block for the current pass.
- des_done  in  1  DES engine result valid (one-cycle pulse).
- des_dout  in  64  DES engine result.
- outputEnable  out  1  `outputData` valid.
- outputData  out  64  triple-DES result.
- outputError  out  1  last operation aborted by timeout.
- busy  out  1  operation in progress.
- dropped  out  1  sticky: an `enable` arrived while busy.

Behaviour:
- **Reset** (HRESET low, asynchronous):
  - State = IDLE; all outputs 0; internal latches (mode, keys, working block, pass count, timer) cleared.
- **States:** IDLE, ISSUE, WAIT, DONE, ERR. All outputs are registered or Moore-decoded; no combinational path from inputs to outputs.
- **Accepting a request** (enable sampled high in IDLE, DONE or ERR):
  - Latch `encryptionType`, `data` and `key1..3` into internal registers.
  - Clear pass = 0, `outputEnable`, `outputError` and `outputData`.
  - Next state = ISSUE.
- **Enable while busy:** `enable` sampled high in ISSUE or WAIT is ignored and sets `dropped`. `dropped` clears only on reset.
- **ISSUE** (one cycle):
  - `des_start` = 1.
  - `des_key`/`des_mode` per pass:
    - Encrypt: pass 0 = (key1, 1), pass 1 = (key2, 0), pass 2 = (key3, 1).
    - Decrypt: pass 0 = (key3, 0), pass 1 = (key2, 1), pass 2 = (key1, 0).
  - `des_din` = latched `data` on pass 0, otherwise the working block.
  - Timer cleared. Next state = WAIT.
- **WAIT:**
  - `des_start` = 0. `des_key`, `des_mode` and `des_din` are held stable.
  - Timer increments every cycle.
  - `des_done` is honoured only in WAIT. A `des_done` in ISSUE or IDLE is ignored.
  - On `des_done`:
    - Working block <= `des_dout`.
    - If pass == 2: `outputData` <= `des_dout`, `outputEnable` <= 1, go to DONE.
    - Otherwise: pass++, go to ISSUE.
  - Timeout: if the timer reaches TIMEOUT-1 without `des_done`, go to ERR with `outputError` <= 1 and `outputData` = 0.
  - If `des_done` and timeout occur in the same cycle, `des_done` wins.
- **busy:** 1 in ISSUE and WAIT, else 0.
- **DONE:**
  - Hold `outputEnable` = 1 and `outputData` until `outputRead`; then clear `outputEnable`, set `outputData` = 0, go to IDLE.
  - `enable` and `outputRead` in the same cycle: `enable` wins (new operation starts, output cleared).
- **ERR:**
  - `outputError` stays 1 until the next accepted `enable`; `outputRead` is ignored.
- **Latency:** with the DES engine asserting `des_done` N edges after the edge sampling `des_start`:
  - `outputEnable` rises 3N+3 edges after the edge sampling `enable`.
  - Throughput is one operation per 3N+4 cycles.
- **Reset mid-operation:** immediate return to IDLE, all outputs 0. A late `des_done` after reset is ignored.

Test Plan:
1. Reset, then idle 10 cycles -> all outputs 0, `busy` 0.
2. Encrypt with mock DES (N=3, dout = din XOR key, ignore mode); data=0x0123456789ABCDEF, key1=0x1, key2=0x2, key3=0x4; `enable` at edge 0 -> `des_key` sequence 0x1,0x2,0x4 with `des_mode` 1,0,1; `outputEnable` at edge 12; `outputData`=0x0123456789ABCDE8; held until `outputRead`.
3. Decrypt with the same keys -> `des_key` sequence 0x4,0x2,0x1 with `des_mode` 0,1,0; `outputData`=0x0123456789ABCDE8.
4. `enable` pulsed during pass 1 WAIT -> ignored, `dropped`=1, result unchanged; `dropped` stays 1 until reset.
5. Mock never asserts `des_done`, TIMEOUT=8 -> ERR reached 8 cycles into WAIT of pass 0; `outputError`=1, `outputEnable`=0; next `enable` clears `outputError` and restarts.
6. HRESET low during pass 1 WAIT, then `des_done` pulsed after release -> all outputs 0, state IDLE, `outputEnable` never rises.
